uart_rx: RTL and testbench

- Serial receiver that is the counterpart of the UART transmit stage.
- Accepts the asynchronous 8N1 line (start bit, 8 data bits LSB first, one stop bit) and recovers the byte using a 16x oversampling tick derived from the system clock.
- Presents the byte to the fabric with a held data-available flag and read-acknowledge handshake.
- Sits between the board RX pin and the consumer logic (loopback/echo path into the transmit stage).

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 16 +
 rtl/uart_baud_tick.sv | 25 ++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and the bit-vote helper.
// Also used by the transmit stage for its bit-count constants.
package uart_pkg;

  localparam int OVS        = 16;
  localparam int MID_SAMPLE = 7;
  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // 2-of-3 vote over three consecutive oversample ticks
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte/handshake/status out.
// slave = the receiver, master = the consumer that drives rx/rd.
interface uart_rx_if;
  logic       rx;
  logic       rd;
  logic [7:0] dout;
  logic       data_avail;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport slave  (input  rx, rd,
                  output dout, data_avail, frame_err, overrun, busy);
  modport master (output rx, rd,
                  input  dout, data_avail, frame_err, overrun, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, restartable via clr.
// Also serves as the transmit-side baud enable.
module uart_baud_tick #(
  parameter int DIV = 326
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] TC = 16'(DIV - 1);

  logic [15:0] r_cnt;

  assign tick = (r_cnt == TC) & ~clr;

  // free-running 0..DIV-1 counter, held at 0 while clr is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_cnt <= '0;
    else if (clr || r_cnt == TC) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 16'd1;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and data_avail/rd handshake.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 voting per bit decision.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line idle, tick counter held, waiting for rx_s low
// START  | counting to mid start bit; high there = false start
// DATA   | sampling 8 data bits one bit period apart, LSB first
// STOP   | sampling stop bit; high = capture, low = framing error
// BREAK  | line held low after a framing error, wait for idle high
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = 326
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam logic [3:0] BIT_DEC = 4'(OVS - 1);

  rx_state_t  r_state, w_state_nxt;
  logic       r_rx_meta, r_rx_s;
  logic [3:0] r_smp;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic [7:0] r_dout;
  logic       r_data_avail, r_frame_err, r_overrun;
  logic       w_tick, w_bit;
  logic       w_smp_clr, w_smp_inc, w_shift_en, w_capture, w_ferr_set;

`ifdef UART_RX_MAJORITY_EN
  // decisions move one tick later so the vote window 6/7/8 is centred
  localparam logic [3:0] START_DEC = 4'(MID_SAMPLE + 1);
  logic [1:0] r_hist;

  // history of the two previous oversample values for the vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_hist <= 2'b11;
    else if (w_tick) r_hist <= {r_hist[0], r_rx_s};
  end

  assign w_bit = maj3(r_hist[1], r_hist[0], r_rx_s);
`else
  localparam logic [3:0] START_DEC = 4'(MID_SAMPLE);
  assign w_bit = r_rx_s;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (r_state == ST_IDLE),
    .tick (w_tick)
  );

  // two-flop synchronizer for the asynchronous pin, idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next state and per-cycle datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_smp_clr   = 1'b0;
    w_smp_inc   = 1'b0;
    w_shift_en  = 1'b0;
    w_capture   = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_smp_clr   = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_smp == START_DEC) begin
            w_smp_clr   = 1'b1;
            w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
          end else begin
            w_smp_inc = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_smp == BIT_DEC) begin
            w_smp_clr  = 1'b1;
            w_shift_en = 1'b1;
            if (r_bit_idx == 3'(FRAME_BITS - 1)) w_state_nxt = ST_STOP;
          end else begin
            w_smp_inc = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_smp == BIT_DEC) begin
            w_smp_clr = 1'b1;
            if (w_bit) begin
              w_capture   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_ferr_set  = 1'b1;
              w_state_nxt = ST_BREAK;
            end
          end else begin
            w_smp_inc = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (r_rx_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // sample counter, shift register and the fabric-facing output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_smp        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_dout       <= '0;
      r_data_avail <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_smp_clr)      r_smp <= '0;
      else if (w_smp_inc) r_smp <= r_smp + 4'd1;

      if (r_state != ST_DATA) r_bit_idx <= '0;
      else if (w_shift_en)    r_bit_idx <= r_bit_idx + 3'd1;

      if (w_shift_en) r_shift <= {w_bit, r_shift[7:1]};

      r_frame_err <= w_ferr_set;
      // a read landing on the capture cycle consumes the old byte, so no overrun
      r_overrun   <= w_capture & r_data_avail & ~bus.rd;

      if (w_capture) begin
        r_dout       <= r_shift;
        r_data_avail <= 1'b1;
      end else if (bus.rd) begin
        r_data_avail <= 1'b0;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.data_avail = r_data_avail;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with DIV=4 (one bit = 64 clk).
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
  localparam int RD_AT_CAP = 614;
  localparam logic [7:0] SPIKE_EXP = 8'hFF;
`else
  localparam int RD_AT_CAP = 610;
  localparam logic [7:0] SPIKE_EXP = 8'hFE;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_rx_if uif();

  uart_rx #(.DIV(4)) dut (.clk(clk), .rst(rst), .bus(uif));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_ferr = 0, n_ovr = 0, n_busy_rise = 0;
  int rise_cyc = -1;
  logic prev_avail = 1'b0, prev_busy = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       pre_rd;
    logic [7:0] exp_dout;
    logic       exp_avail;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  // pulse/edge counters sampled away from the active edge
  always @(negedge clk) begin
    if (uif.frame_err) n_ferr++;
    if (uif.overrun) n_ovr++;
    if (uif.busy && !prev_busy) n_busy_rise++;
    if (uif.data_avail && !prev_avail) rise_cyc = cyc;
    prev_busy  = uif.busy;
    prev_avail = uif.data_avail;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // frame is left on the stop level; callers return the line to idle
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len);
    uif.rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uif.rx = d[i];
      repeat (64) @(negedge clk);
    end
    uif.rx = stop_v;
    repeat (stop_len) @(negedge clk);
  endtask

  task automatic pulse_rd();
    uif.rd = 1'b1;
    @(negedge clk);
    uif.rd = 1'b0;
  endtask

  int f0, o0, b0, st, lat;

  initial begin
    vecs[0] = '{8'h96, 1'b1, 1'b0, 8'h96, 1'b1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h96, 1'b0, 1, 0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 0, 1};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 0, 0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1, 0};

    uif.rx = 1'b1;
    uif.rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", uif.dout, 8'h00);
    chk("rst_avail", uif.data_avail, 0);
    chk("rst_ferr", uif.frame_err, 0);
    chk("rst_ovr", uif.overrun, 0);
    chk("rst_busy", uif.busy, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 0xA5: latency, capture, then rd clears data_avail on the next clk
    f0 = n_ferr; st = cyc; rise_cyc = -1;
    send_frame(8'hA5, 1'b1, 64);
    uif.rx = 1'b1;
    lat = (rise_cyc < 0) ? -1 : rise_cyc - st;
    chk("a5_latency_ok", (lat >= 600 && lat <= 625), 1);
    chk("a5_dout", uif.dout, 8'hA5);
    chk("a5_avail", uif.data_avail, 1);
    chk("a5_ferr", n_ferr - f0, 0);
    pulse_rd();
    chk("a5_rd_clears", uif.data_avail, 0);
    pulse_rd();
    chk("rd_when_empty", uif.data_avail, 0);

    // 20-clk glitch: false start
    f0 = n_ferr; b0 = n_busy_rise;
    uif.rx = 1'b0;
    repeat (20) @(negedge clk);
    uif.rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_busy_rise", n_busy_rise - b0, 1);
    chk("glitch_busy_low", uif.busy, 0);
    chk("glitch_avail", uif.data_avail, 0);
    chk("glitch_ferr", n_ferr - f0, 0);

    // bad stop, line held low: single frame_err, stays in BREAK
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 64);
    repeat (200) @(negedge clk);
    chk("brk_ferr_once", n_ferr - f0, 1);
    chk("brk_busy", uif.busy, 1);
    chk("brk_dout_kept", uif.dout, 8'hA5);
    chk("brk_avail", uif.data_avail, 0);
    uif.rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("brk_exit", uif.busy, 0);

    // table-driven frames
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].pre_rd) pulse_rd();
      f0 = n_ferr; o0 = n_ovr;
      send_frame(vecs[v].data, vecs[v].stop_ok, 64);
      uif.rx = 1'b1;
      repeat (20) @(negedge clk);
      chk($sformatf("vec%0d_dout", v), uif.dout, vecs[v].exp_dout);
      chk($sformatf("vec%0d_avail", v), uif.data_avail, vecs[v].exp_avail);
      chk($sformatf("vec%0d_ferr", v), n_ferr - f0, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_ovr", v), n_ovr - o0, vecs[v].exp_ovr);
      chk($sformatf("vec%0d_busy", v), uif.busy, 0);
    end

    // back-to-back: next start edge 5 clk after the stop midpoint
    pulse_rd();
    f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h11, 1'b1, 40);
    send_frame(8'h22, 1'b1, 64);
    uif.rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("b2b_dout", uif.dout, 8'h22);
    chk("b2b_avail", uif.data_avail, 1);
    chk("b2b_ovr", n_ovr - o0, 1);
    chk("b2b_ferr", n_ferr - f0, 0);

    // rd on the exact capture cycle: capture wins, no overrun
    o0 = n_ovr;
    fork
      send_frame(8'h77, 1'b1, 64);
      begin
        repeat (RD_AT_CAP) @(negedge clk);
        uif.rd = 1'b1;
        @(negedge clk);
        uif.rd = 1'b0;
      end
    join
    uif.rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("rdcap_dout", uif.dout, 8'h77);
    chk("rdcap_avail", uif.data_avail, 1);
    chk("rdcap_ovr", n_ovr - o0, 0);

    // reset in the middle of bit 4 of 0xFF
    uif.rx = 1'b0;
    repeat (64) @(negedge clk);
    uif.rx = 1'b1;
    repeat (286) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_dout", uif.dout, 8'h00);
    chk("mid_rst_avail", uif.data_avail, 0);
    chk("mid_rst_busy", uif.busy, 0);
    chk("mid_rst_ferr", uif.frame_err, 0);
    chk("mid_rst_ovr", uif.overrun, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("post_rst_idle", uif.busy, 0);
    send_frame(8'h5A, 1'b1, 64);
    uif.rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_dout", uif.dout, 8'h5A);
    chk("post_rst_avail", uif.data_avail, 1);

    // 4-clk low spike centred in data bit 0 of 0xFF
    pulse_rd();
    uif.rx = 1'b0;
    repeat (64) @(negedge clk);
    uif.rx = 1'b1;
    repeat (30) @(negedge clk);
    uif.rx = 1'b0;
    repeat (4) @(negedge clk);
    uif.rx = 1'b1;
    repeat (30 + 7 * 64 + 64) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("spike_dout", uif.dout, SPIKE_EXP);
    chk("spike_avail", uif.data_avail, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
